uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer that shares one single-byte UART transmitter among NUM_REQ requesters.
//  - Accepts one byte at a time from a requester using a req/ack handshake.
//  - Drives the transmitter's send_en and data-byte inputs.
//  - Holds the byte stable until the transmitter's done pulse, then enforces an idle gap.
//  - A watchdog recovers if the done pulse never arrives. Sits between message sources and the byte transmitter.
// PARAMETERS
//  NUM_REQ         4      number of requesters, 2..8
//  GAP_CYCLES      16     idle clk cycles between tx_done and the next grant; 0 = no gap
//  TIMEOUT_CYCLES  32768  clk cycles in WAIT without tx_done before abort; must be >= 1
// PORTS
//  clk        in   1          system clock; all logic on the rising edge
//  rst        in   1          asynchronous, active-high reset
//  req        in   NUM_REQ    per-requester byte-valid; held high with data until that requester's ack
//  req_data   in   8*NUM_REQ  byte of requester i on bits [8i+7:8i]
//  req_ack    out  NUM_REQ    one-hot, 1-cycle pulse: byte of that requester latched
//  send_en    out  1          1-cycle start pulse to the transmitter
//  tx_byte    out  8          byte to the transmitter; stable from latch until leaving WAIT
//  tx_done    in   1          1-cycle done pulse from the transmitter
//  grant_id   out  3          index of the requester currently being served
//  busy       out  1          high in every state except IDLE
//  timeout_err out 1          1-cycle pulse when the watchdog aborts a frame
// BEHAVIOUR
//  Reset
//   - All outputs 0; state = IDLE.
//   - Round-robin pointer last = NUM_REQ-1, so requester 0 has top priority first.
//   - Reset mid-frame drops the frame silently; no ack and no err are issued.
//  States: IDLE, SEND, WAIT, GAP. All outputs are registered.
//  IDLE
//   - Condition: any req bit is high at edge k.
//   - Winner = first requester with req high, searching last+1, last+2, ... modulo NUM_REQ.
//   - After edge k: tx_byte <= winner's byte, req_ack[winner] = 1 for one cycle, grant_id <= winner, last <= winner, busy = 1, state -> SEND.
//  SEND
//   - send_en = 1 for exactly one cycle; state -> WAIT.
//   - Latency from req sampled to send_en high = 2 edges.
//  WAIT
//   - The watchdog counter counts clk cycles.
//   - On tx_done: state -> GAP, or -> IDLE if GAP_CYCLES == 0.
//   - Otherwise, once the counter reaches TIMEOUT_CYCLES: timeout_err pulses for 1 cycle, then the same transition as tx_done.
//   - tx_done and timeout in the same cycle: tx_done wins and no err is raised.
//  GAP
//   - The counter loads GAP_CYCLES-1 on entry and decrements to 0, then state -> IDLE.
//   - The next grant therefore occurs no earlier than GAP_CYCLES+1 cycles after tx_done.
//  tx_done outside WAIT (IDLE, SEND, GAP) is ignored.
//  req changes during SEND/WAIT/GAP are ignored until IDLE.
//  A requester that keeps req high after its ack re-competes at the next IDLE; round-robin prevents starvation.
//  Counters are sized to clog2(max(TIMEOUT_CYCLES, GAP_CYCLES) + 1) bits and never wrap.
//  Never issue a new send_en before tx_done or timeout of the previous frame.
// TESTING (GAP_CYCLES=2, TIMEOUT_CYCLES=50, transmitter model returns tx_done 20 cycles after send_en)
//  1. Reset, then req=4'b0001, data0=8'hA5
//     -> req_ack=0001 one cycle; send_en one cycle later; tx_byte=A5 held until tx_done; busy falls 3 cycles after tx_done.
//  2. req=4'b1111 held, bytes 11/22/33/44
//     -> send order 11,22,33,44,11; each ack exactly once per frame; grant_id 0,1,2,3,0.
//  3. Model never returns tx_done
//     -> timeout_err pulses 50 cycles after entering WAIT; FSM returns to IDLE; the next request is served normally.
//  4. Spurious tx_done in IDLE and in SEND
//     -> no state change, no extra send_en, no ack.
//  5. Assert rst during WAIT
//     -> all outputs 0 asynchronously; after release, req=0010 is granted first over pending 0100 (pointer reset).
//  6. tx_done and timeout coincide at cycle 50
//     -> no timeout_err; normal transition to GAP.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one byte-wide UART
//            transmitter among NUM_REQ requesters, with idle gap and watchdog.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 32768
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   send_en,
    output logic [7:0]             tx_byte,
    input  logic                   tx_done,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int c_CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD = c_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0]         c_LAST_RST = 3'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]           r_last;
    logic [2:0]           w_last_nxt;

    logic                 w_found;
    logic [2:0]           w_winner;
    logic [7:0]           w_win_byte;

    logic [NUM_REQ-1:0]   w_ack_nxt;
    logic                 w_send_nxt;
    logic [7:0]           w_byte_nxt;
    logic [2:0]           w_grant_nxt;
    logic                 w_busy_nxt;
    logic                 w_err_nxt;
    logic                 w_leave;

    // Search strictly above the last winner first, then wrap to 0..last.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_win_byte = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && req[j] && (j > int'(r_last))) begin
                w_found    = 1'b1;
                w_winner   = 3'(j);
                w_win_byte = req_data[8*j +: 8];
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && req[j] && (j <= int'(r_last))) begin
                w_found    = 1'b1;
                w_winner   = 3'(j);
                w_win_byte = req_data[8*j +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_ack_nxt   = '0;
        w_send_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_byte_nxt  = tx_byte;
        w_grant_nxt = grant_id;
        w_leave     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_SEND;
                    w_byte_nxt  = w_win_byte;
                    w_ack_nxt   = NUM_REQ'(1) << w_winner;
                    w_grant_nxt = w_winner;
                    w_last_nxt  = w_winner;
                end
            end
            S_SEND: begin
                w_state_nxt = S_WAIT;
                w_send_nxt  = 1'b1;
                w_cnt_nxt   = '0;
            end
            S_WAIT: begin
                // tx_done takes precedence over a coincident watchdog expiry.
                if (tx_done) begin
                    w_leave = 1'b1;
                end else if (r_cnt == c_TO_LAST) begin
                    w_leave   = 1'b1;
                    w_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                if (w_leave) begin
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = c_GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last      <= c_LAST_RST;
            req_ack     <= '0;
            send_en     <= 1'b0;
            tx_byte     <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last      <= w_last_nxt;
            req_ack     <= w_ack_nxt;
            send_en     <= w_send_nxt;
            tx_byte     <= w_byte_nxt;
            grant_id    <= w_grant_nxt;
            busy        <= w_busy_nxt;
            timeout_err <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench: timestamp-based frame model plus directed cases.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int c_N   = 4;
    localparam int c_GAP = 2;
    localparam int c_TO  = 50;

    logic              clk = 1'b0;
    logic              rst;
    logic [c_N-1:0]    req;
    logic [8*c_N-1:0]  req_data;
    logic [c_N-1:0]    req_ack;
    logic              send_en;
    logic [7:0]        tx_byte;
    logic              tx_done;
    logic [2:0]        grant_id;
    logic              busy;
    logic              timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ        (c_N),
        .GAP_CYCLES     (c_GAP),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .send_en     (send_en),
        .tx_byte     (tx_byte),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int tx_delay = 20;

    logic [c_N-1:0] s_req  = '0;
    logic           s_done = 1'b0;
    logic           s_rst  = 1'b0;

    always @(posedge clk) begin
        s_req  <= req;
        s_done <= tx_done;
        s_rst  <= rst;
        cyc    <= cyc + 1;
    end

    // event log filled by the compare process
    int   ack_cyc, send_cyc, done_cyc, fall_cyc, err_cyc;
    int   send_cnt = 0;
    int   err_cnt  = 0;
    int   ack_cnt [c_N];
    logic [7:0] send_q [$];
    logic [2:0] grant_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Frame model: a frame is described by its grant edge and its end edge;
    // every output is derived from the current edge's distance to those.
    initial begin : p_model
        bit   m_active;
        int   m_last, m_win, m_t_grant, m_t_end, m_free_at, idx;
        bit   m_to, found, prev_busy;
        logic [7:0] m_byte;
        logic [2:0] m_grant;
        logic [c_N-1:0] e_ack;
        m_active = 0; m_last = c_N - 1; m_win = 0; m_t_grant = -100; m_t_end = -1;
        m_free_at = 0; m_to = 0; m_byte = '0; m_grant = '0; prev_busy = 0;
        forever begin
            @(negedge clk);
            if (rst || s_rst) begin
                m_active = 0; m_last = c_N - 1; m_byte = '0; m_grant = '0;
                m_free_at = 0; m_t_grant = -100; m_t_end = -1; m_to = 0;
            end else if (m_active) begin
                if (m_t_end < 0 && cyc >= m_t_grant + 2) begin
                    if (s_done) begin
                        m_t_end = cyc; m_to = 0;
                    end else if (cyc == m_t_grant + 1 + c_TO) begin
                        m_t_end = cyc; m_to = 1;
                    end
                end
                if (m_t_end >= 0 && cyc == m_t_end + c_GAP) begin
                    m_active  = 0;
                    m_free_at = cyc + 1;
                end
            end else if (cyc >= m_free_at && s_req != 0) begin
                found = 0;
                for (int k = 1; k <= c_N; k++) begin
                    idx = (m_last + k) % c_N;
                    if (!found && s_req[idx]) begin
                        found = 1; m_win = idx;
                    end
                end
                m_last    = m_win;
                m_byte    = req_data[8*m_win +: 8];
                m_grant   = 3'(m_win);
                m_active  = 1;
                m_t_grant = cyc;
                m_t_end   = -1;
                m_to      = 0;
            end

            e_ack = (m_active && cyc == m_t_grant) ? c_N'(1) << m_win : '0;
            chk("req_ack", 32'(req_ack), 32'(e_ack));
            chk("send_en", 32'(send_en), 32'(m_active && cyc == m_t_grant + 1));
            chk("timeout_err", 32'(timeout_err), 32'(m_to && cyc == m_t_end));
            chk("busy", 32'(busy), 32'(m_active));
            chk("tx_byte", 32'(tx_byte), 32'(m_byte));
            chk("grant_id", 32'(grant_id), 32'(m_grant));

            if (req_ack != 0) begin
                ack_cyc = cyc;
                for (int j = 0; j < c_N; j++) if (req_ack[j]) ack_cnt[j]++;
            end
            if (send_en) begin
                send_cyc = cyc; send_cnt++;
                send_q.push_back(tx_byte);
                grant_q.push_back(grant_id);
            end
            if (tx_done) done_cyc = cyc;
            if (prev_busy && !busy) fall_cyc = cyc;
            prev_busy = busy;
            if (timeout_err) begin
                err_cnt++; err_cyc = cyc;
            end
        end
    end

    // Transmitter stand-in: done pulse tx_delay cycles after send_en (0 = never).
    initial begin
        forever begin
            @(negedge clk);
            if (send_en && tx_delay > 0) begin
                repeat (tx_delay) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    task automatic pulse_reset();
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #3 rst = 1'b0;
    endtask

    task automatic send_req(input logic [c_N-1:0] mask);
        bit got;
        got = 0;
        @(posedge clk); #1 req = mask;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if ((req_ack & mask) != 0) begin
                req = req & ~req_ack;
                got = 1;
            end
        end
        if (!got) begin
            bound_fail("ack_wait");
            req = '0;
        end
    endtask

    task automatic wait_idle();
        bit done_w;
        done_w = 0;
        for (int i = 0; i < 300 && !done_w; i++) begin
            @(negedge clk);
            if (!busy) done_w = 1;
        end
        if (!done_w) bound_fail("idle_wait");
        @(posedge clk); #1;
    endtask

    initial begin : p_stim
        int k, save_err, save_send;
        logic [7:0] exp_bytes [5];
        logic [2:0] exp_grants [5];
        rst = 1'b1; req = '0; req_data = '0; tx_done = 1'b0;
        for (int j = 0; j < c_N; j++) ack_cnt[j] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_send_en", 32'(send_en), 0);
        chk("rst_req_ack", 32'(req_ack), 0);
        chk("rst_tx_byte", 32'(tx_byte), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        #2 rst = 1'b0;

        // 1: single request
        req_data[7:0] = 8'hA5;
        send_req(4'b0001);
        wait_idle();
        chk("t1_ack_to_send", 32'(send_cyc - ack_cyc), 1);
        chk("t1_tx_byte", 32'(tx_byte), 32'h A5);
        chk("t1_done_to_busy_fall", 32'(fall_cyc - done_cyc), 3);
        chk("t1_ack_count", 32'(ack_cnt[0]), 1);

        // 2: all four held, round robin from reset
        pulse_reset();
        send_q.delete(); grant_q.delete();
        for (int j = 0; j < c_N; j++) ack_cnt[j] = 0;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        exp_bytes  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        exp_grants = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        @(posedge clk); #1 req = 4'b1111;
        k = 0;
        for (int i = 0; i < 400 && k < 5; i++) begin
            @(negedge clk);
            if (req_ack != 0) k++;
            if (k == 5) req = '0;
        end
        if (k < 5) begin
            bound_fail("t2_acks");
            req = '0;
        end
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_byte%0d", i), (i < send_q.size()) ? 32'(send_q[i]) : 32'hFFFF, 32'(exp_bytes[i]));
            chk($sformatf("t2_grant%0d", i), (i < grant_q.size()) ? 32'(grant_q[i]) : 32'hFFFF, 32'(exp_grants[i]));
        end
        chk("t2_ack0", 32'(ack_cnt[0]), 2);
        chk("t2_ack1", 32'(ack_cnt[1]), 1);
        chk("t2_ack2", 32'(ack_cnt[2]), 1);
        chk("t2_ack3", 32'(ack_cnt[3]), 1);

        // 3: transmitter never answers
        tx_delay = 0;
        save_err = err_cnt;
        req_data[7:0] = 8'h5A;
        send_req(4'b0001);
        wait_idle();
        chk("t3_err_count", 32'(err_cnt - save_err), 1);
        chk("t3_err_latency", 32'(err_cyc - send_cyc), 50);
        tx_delay = 20;
        req_data[15:8] = 8'h77;
        send_req(4'b0010);
        wait_idle();
        chk("t3_no_second_err", 32'(err_cnt - save_err), 1);
        chk("t3_recovered_byte", (send_q.size() > 0) ? 32'(send_q[$]) : 32'hFFFF, 32'h77);

        // 4: spurious tx_done in IDLE and in SEND
        save_send = send_cnt;
        save_err  = err_cnt;
        @(posedge clk); #1 tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_idle_busy", 32'(busy), 0);
        chk("t4_idle_sends", 32'(send_cnt - save_send), 0);
        req_data[23:16] = 8'hC3;
        @(posedge clk); #1 req = 4'b0100;
        k = 0;
        for (int i = 0; i < 50 && k == 0; i++) begin
            @(negedge clk);
            if (req_ack != 0) begin
                k = 1; req = '0; tx_done = 1'b1;
            end
        end
        if (k == 0) bound_fail("t4_ack");
        @(posedge clk); #1 tx_done = 1'b0;
        wait_idle();
        chk("t4_sends", 32'(send_cnt - save_send), 1);
        chk("t4_done_to_busy_fall", 32'(fall_cyc - done_cyc), 3);
        chk("t4_no_err", 32'(err_cnt - save_err), 0);

        // 5: reset during WAIT, pointer restarts
        tx_delay = 0;
        save_err = err_cnt;
        req_data[7:0] = 8'h0F;
        send_req(4'b0001);
        k = 0;
        for (int i = 0; i < 20 && k == 0; i++) begin
            @(negedge clk);
            if (send_en) k = 1;
        end
        if (k == 0) bound_fail("t5_send");
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_tx_byte", 32'(tx_byte), 0);
        chk("t5_grant_id", 32'(grant_id), 0);
        chk("t5_err", 32'(timeout_err), 0);
        req_data[15:8]  = 8'hB1;
        req_data[23:16] = 8'hB2;
        req = 4'b0110;
        tx_delay = 20;
        @(posedge clk); #3 rst = 1'b0;
        k = 0;
        for (int i = 0; i < 20 && k == 0; i++) begin
            @(negedge clk);
            if (req_ack != 0) begin
                k = 1;
                chk("t5_first_grant", 32'(grant_id), 1);
                chk("t5_first_ack", 32'(req_ack), 32'b0010);
                req = '0;
            end
        end
        if (k == 0) begin
            bound_fail("t5_ack");
            req = '0;
        end
        wait_idle();
        chk("t5_no_err", 32'(err_cnt - save_err), 0);

        // 6: tx_done on the very cycle the watchdog would expire
        tx_delay = 49;
        save_err = err_cnt;
        req_data[31:24] = 8'hE6;
        send_req(4'b1000);
        wait_idle();
        chk("t6_no_err", 32'(err_cnt - save_err), 0);
        chk("t6_done_latency", 32'(done_cyc - send_cyc), 49);
        chk("t6_busy_fall", 32'(fall_cyc - send_cyc), 52);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
